l2_subset_request_issuer: RTL and testbench
===========================================

// Module: l2_subset_request_issuer
// PURPOSE
// Initiator side of the L2 subset-simulator lookup handshake. Buffers L1 miss events
// (set index + stack-distance way) in a FIFO, issues one find_start lookup at a time to
// the L2 subset block, and waits for its updated pulse. It then returns the hit/source
// result upstream and keeps request/hit/miss statistics for the multicore simulator.
// PARAMETERS
// WAY        16   L2 associativity simulated by the subset block
// SET_SIZE   512  sets per mask bank
// SET_INDEX  9    log2(SET_SIZE); msb_index is SET_INDEX+1 bits (bank-select MSB + set)
// WAY_WIDTH  4    log2(WAY); hit_way/hit_source are WAY_WIDTH+1 bits
// FIFO_DEPTH 8    miss-request FIFO entries (power of two, >=2)
// TIMEOUT    64   max cycles in WAIT before the watchdog fires
// CNT_W      20   statistics counter width
// PORTS
// clk            in   1            clock
// reset          in   1            synchronous, active-high
// miss_valid     in   1            L1 miss request present
// miss_index     in   SET_INDEX+1  request msb_index (bit SET_INDEX = bank, rest = set)
// miss_way       in   WAY_WIDTH+1  request stack-distance way
// miss_ready     out  1            FIFO can accept (= !full)
// find_start     out  1            one-cycle lookup strobe to L2 subset
// msb_index      out  SET_INDEX+1  lookup index, held stable from find_start to DRAIN exit
// hit_way        out  WAY_WIDTH+1  lookup way, held like msb_index
// found_in_cache in   1            L2 result, sampled only when updated=1
// hit_source     in   WAY_WIDTH+1  L2 source position, sampled only when updated=1
// updated        in   1            L2 lookup/update complete
// resp_valid     out  1            one-cycle result strobe
// resp_hit       out  1            captured found_in_cache
// resp_source    out  WAY_WIDTH+1  captured hit_source (WAY on miss)
// req_count      out  CNT_W        lookups completed
// hit_count      out  CNT_W        completed lookups with found_in_cache=1
// miss_count     out  CNT_W        completed lookups with found_in_cache=0
// err_timeout    out  1            sticky watchdog error
// busy           out  1            FSM != IDLE or FIFO non-empty
// BEHAVIOUR
// - Reset (sync, active-high): all outputs 0, FIFO empty (miss_ready=1), FSM=IDLE,
//   counters 0, err_timeout 0. Reset mid-lookup abandons it; no resp_valid emitted.
// - FIFO: push on miss_valid&&miss_ready. miss_ready=!full even if a pop occurs the same
//   cycle (no full-bypass). Pointers wrap modulo FIFO_DEPTH. Push into empty FIFO
//   with IDLE FSM: find_start high in the 2nd cycle after the accepting edge.
// - FSM (all outputs registered):
//   IDLE : FIFO non-empty -> load msb_index/hit_way from head, pop, find_start<=1, ->WAIT.
//   WAIT : find_start<=0 (exactly one-cycle strobe). wdog++ each cycle.
//          updated=1 -> resp_valid<=1, resp_hit<=found_in_cache, resp_source<=hit_source,
//          req_count++, hit_count++ or miss_count++, wdog<=0, ->DRAIN.
//          wdog reaches TIMEOUT-1 with updated=0 -> err_timeout<=1, ->HALT.
//   DRAIN: resp_valid<=0; updated=0 -> IDLE (guarantees L2 back in its idle state
//          before next strobe). Min 1 cycle here.
//   HALT : no further lookups, FIFO still accepts until full; exit only by reset.
// - updated seen in IDLE/DRAIN/HALT is ignored (no counter change).
// - msb_index/hit_way change only on IDLE->WAIT load.
// - Counters saturate at 2^CNT_W-1; req_count = hit_count + miss_count until saturation.
// - Max throughput: one lookup per (4 + L2 latency) cycles; no overlap of lookups.
// TESTING
// 1 Reset: after reset, miss_ready=1, find_start=0, busy=0, all counters 0, err_timeout=0.
// 2 Single hit: push index=0x105 way=2; L2 model asserts updated 3 cycles after strobe
//   with found=1 source=5 -> one find_start pulse, msb_index=0x105 hit_way=2 held,
//   resp_valid 1 cycle with resp_hit=1 resp_source=5, req=1 hit=1 miss=0.
// 3 Miss: push index=0x00A way=16, L2 returns found=0 source=16 -> resp_hit=0,
//   resp_source=16, miss_count=1.
// 4 Back-pressure: push 9 entries back-to-back, L2 stalled -> miss_ready low after 8th
//   (FIFO_DEPTH) or 9th (one popped); all 9 served in order, req_count=9.
// 5 Watchdog: L2 model never asserts updated -> err_timeout=1 exactly 64 cycles after
//   strobe, no further find_start, busy stays 1 until reset.
// 6 Reset mid-WAIT: reset 2 cycles after strobe -> no resp_valid, counters 0, FIFO empty.

Source files
------------

// File: rtl/l2_subset_request_issuer.sv
// Initiator for the L2 subset-simulator lookup handshake. L1 miss events queue in a
// FIFO and go out one at a time; results and hit/miss statistics are reported upstream.
module l2_subset_request_issuer #(
  parameter int WAY        = 16,
  parameter int SET_SIZE   = 512,
  parameter int SET_INDEX  = 9,
  parameter int WAY_WIDTH  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 miss_valid,
  input  logic [SET_INDEX:0]   miss_index,
  input  logic [WAY_WIDTH:0]   miss_way,
  output logic                 miss_ready,
  output logic                 find_start,
  output logic [SET_INDEX:0]   msb_index,
  output logic [WAY_WIDTH:0]   hit_way,
  input  logic                 found_in_cache,
  input  logic [WAY_WIDTH:0]   hit_source,
  input  logic                 updated,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAY_WIDTH:0]   resp_source,
  output logic [CNT_W-1:0]     req_count,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic                 err_timeout,
  output logic                 busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  // Reject inconsistent geometry at elaboration rather than simulating garbage.
  if (SET_SIZE != (1 << SET_INDEX)) begin : g_bad_set_size
    $error("SET_SIZE must equal 2**SET_INDEX");
  end
  if (WAY != (1 << WAY_WIDTH)) begin : g_bad_way
    $error("WAY must equal 2**WAY_WIDTH");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH != (1 << PTR_W)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [SET_INDEX:0] index;
    logic [WAY_WIDTH:0] way;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } state_t;

  // ---------------------------------------------------------------- FIFO
  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     fill;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  entry_t             head;

  assign full       = (fill == (PTR_W+1)'(FIFO_DEPTH));
  assign empty      = (fill == '0);
  assign miss_ready = !full;
  assign push       = miss_valid && !full;
  assign head       = mem[rd_ptr];

  // NOTE: storage carries no reset; only the pointers and fill level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{index: miss_index, way: miss_way};
    end
  end

  // NOTE: all sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (PTR_W+1)'(1);
        2'b01:   fill <= fill - (PTR_W+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t             state_q;
  state_t             state_d;
  logic [WDOG_W-1:0]  wdog_q;
  logic [WDOG_W-1:0]  wdog_d;
  logic               find_start_d;
  logic               resp_valid_d;
  logic               resp_hit_d;
  logic [WAY_WIDTH:0] resp_source_d;
  logic [SET_INDEX:0] msb_index_d;
  logic [WAY_WIDTH:0] hit_way_d;
  logic               err_d;
  logic               count_en;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    wdog_d        = wdog_q;
    find_start_d  = 1'b0;
    resp_valid_d  = 1'b0;
    resp_hit_d    = resp_hit;
    resp_source_d = resp_source;
    msb_index_d   = msb_index;
    hit_way_d     = hit_way;
    err_d         = err_timeout;
    pop           = 1'b0;
    count_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          msb_index_d  = head.index;
          hit_way_d    = head.way;
          pop          = 1'b1;
          find_start_d = 1'b1;
          wdog_d       = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (updated) begin
          resp_valid_d  = 1'b1;
          resp_hit_d    = found_in_cache;
          resp_source_d = hit_source;
          count_en      = 1'b1;
          wdog_d        = '0;
          state_d       = S_DRAIN;
        end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_DRAIN: begin
        // Wait for the L2 side to drop updated so the next strobe finds it idle.
        if (!updated) state_d = S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wdog_q      <= '0;
      find_start  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_source <= '0;
      msb_index   <= '0;
      hit_way     <= '0;
      err_timeout <= 1'b0;
      req_count   <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      find_start  <= find_start_d;
      resp_valid  <= resp_valid_d;
      resp_hit    <= resp_hit_d;
      resp_source <= resp_source_d;
      msb_index   <= msb_index_d;
      hit_way     <= hit_way_d;
      err_timeout <= err_d;
      if (count_en) begin
        req_count <= sat_inc(req_count);
        if (found_in_cache) hit_count  <= sat_inc(hit_count);
        else                miss_count <= sat_inc(miss_count);
      end
    end
  end

  assign busy = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_l2_subset_request_issuer.sv
// Directed bench for l2_subset_request_issuer with a small behavioural L2 responder.
module tb_l2_subset_request_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_valid;
  logic [9:0]  miss_index;
  logic [4:0]  miss_way;
  logic        miss_ready;
  logic        find_start;
  logic [9:0]  msb_index;
  logic [4:0]  hit_way;
  logic        found_in_cache;
  logic [4:0]  hit_source;
  logic        updated;
  logic        resp_valid;
  logic        resp_hit;
  logic [4:0]  resp_source;
  logic [19:0] req_count;
  logic [19:0] hit_count;
  logic [19:0] miss_count;
  logic        err_timeout;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // L2 responder controls
  logic        l2_en    = 1'b0;
  logic        l2_echo  = 1'b0;
  int          l2_lat   = 3;
  logic        l2_found = 1'b0;
  logic [4:0]  l2_src   = '0;

  // Observation results filled by collect()
  int          n_start;
  int          hold_bad;
  logic        resp_hit_q [$];
  logic [4:0]  resp_src_q [$];

  l2_subset_request_issuer dut (
    .clk            (clk),
    .reset          (reset),
    .miss_valid     (miss_valid),
    .miss_index     (miss_index),
    .miss_way       (miss_way),
    .miss_ready     (miss_ready),
    .find_start     (find_start),
    .msb_index      (msb_index),
    .hit_way        (hit_way),
    .found_in_cache (found_in_cache),
    .hit_source     (hit_source),
    .updated        (updated),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .resp_source    (resp_source),
    .req_count      (req_count),
    .hit_count      (hit_count),
    .miss_count     (miss_count),
    .err_timeout    (err_timeout),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Behavioural L2: answers a strobe l2_lat cycles later with a one-cycle updated pulse.
  // In echo mode the source is the strobed way and found is bit 0 of the index.
  initial begin
    logic [9:0] cap_idx;
    logic [4:0] cap_way;
    updated        = 1'b0;
    found_in_cache = 1'b0;
    hit_source     = '0;
    forever begin
      @(posedge clk); #1;
      if (find_start && l2_en) begin
        cap_idx = msb_index;
        cap_way = hit_way;
        repeat (l2_lat) begin @(posedge clk); #1; end
        updated        = 1'b1;
        found_in_cache = l2_echo ? cap_idx[0] : l2_found;
        hit_source     = l2_echo ? cap_way : l2_src;
        @(posedge clk); #1;
        updated        = 1'b0;
        found_in_cache = 1'b0;
        hit_source     = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Runs a fixed number of cycles, counting strobes, logging responses and watching
  // that the lookup index/way only move together with a strobe.
  task automatic collect(input int cycles);
    logic [9:0] prev_idx;
    logic [4:0] prev_way;
    n_start  = 0;
    hold_bad = 0;
    resp_hit_q.delete();
    resp_src_q.delete();
    prev_idx = msb_index;
    prev_way = hit_way;
    repeat (cycles) begin
      step();
      if (find_start) n_start++;
      else if (msb_index !== prev_idx || hit_way !== prev_way) hold_bad++;
      if (resp_valid) begin
        resp_hit_q.push_back(resp_hit);
        resp_src_q.push_back(resp_source);
      end
      prev_idx = msb_index;
      prev_way = hit_way;
    end
  endtask

  task automatic check_counts(input string tag, input int req, input int hit, input int miss);
    total++;
    if (req_count !== 20'(req)) begin
      bad++; $display("FAIL %s req_count: got %0d expected %0d", tag, req_count, req);
    end
    total++;
    if (hit_count !== 20'(hit)) begin
      bad++; $display("FAIL %s hit_count: got %0d expected %0d", tag, hit_count, hit);
    end
    total++;
    if (miss_count !== 20'(miss)) begin
      bad++; $display("FAIL %s miss_count: got %0d expected %0d", tag, miss_count, miss);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; miss_valid = 1'b0; miss_index = '0; miss_way = '0;
    step(); step();
    reset = 1'b0;
    step();
    total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL reset miss_ready: got %b expected 1", miss_ready); end
    total++; if (find_start !== 1'b0) begin bad++; $display("FAIL reset find_start: got %b expected 0", find_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", busy); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset err_timeout: got %b expected 0", err_timeout); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset resp_valid: got %b expected 0", resp_valid); end
    total++; if (msb_index !== 10'h000) begin bad++; $display("FAIL reset msb_index: got %h expected 000", msb_index); end
    check_counts("reset", 0, 0, 0);
  endtask

  task automatic test_single_hit();
    l2_en = 1'b1; l2_echo = 1'b0; l2_lat = 3; l2_found = 1'b1; l2_src = 5'd5;
    miss_valid = 1'b1; miss_index = 10'h105; miss_way = 5'd2;
    step();
    miss_valid = 1'b0;
    total++; if (find_start !== 1'b0) begin bad++; $display("FAIL hit early_strobe: got %b expected 0", find_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hit busy_queued: got %b expected 1", busy); end
    step();
    total++; if (find_start !== 1'b1) begin bad++; $display("FAIL hit strobe: got %b expected 1", find_start); end
    total++; if (msb_index !== 10'h105) begin bad++; $display("FAIL hit msb_index: got %h expected 105", msb_index); end
    total++; if (hit_way !== 5'd2) begin bad++; $display("FAIL hit hit_way: got %0d expected 2", hit_way); end
    collect(12);
    total++; if (n_start !== 0) begin bad++; $display("FAIL hit extra_strobes: got %0d expected 0", n_start); end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL hit hold: got %0d changes expected 0", hold_bad); end
    total++; if (resp_hit_q.size() !== 1) begin bad++; $display("FAIL hit resp_pulses: got %0d expected 1", resp_hit_q.size()); end
    if (resp_hit_q.size() > 0) begin
      total++; if (resp_hit_q[0] !== 1'b1) begin bad++; $display("FAIL hit resp_hit: got %b expected 1", resp_hit_q[0]); end
      total++; if (resp_src_q[0] !== 5'd5) begin bad++; $display("FAIL hit resp_source: got %0d expected 5", resp_src_q[0]); end
    end
    total++; if (msb_index !== 10'h105) begin bad++; $display("FAIL hit msb_hold_after: got %h expected 105", msb_index); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hit busy_after: got %b expected 0", busy); end
    check_counts("hit", 1, 1, 0);
  endtask

  task automatic test_miss();
    l2_en = 1'b1; l2_echo = 1'b0; l2_lat = 2; l2_found = 1'b0; l2_src = 5'd16;
    miss_valid = 1'b1; miss_index = 10'h00A; miss_way = 5'd16;
    step();
    miss_valid = 1'b0;
    collect(12);
    total++; if (n_start !== 1) begin bad++; $display("FAIL miss strobes: got %0d expected 1", n_start); end
    total++; if (resp_hit_q.size() !== 1) begin bad++; $display("FAIL miss resp_pulses: got %0d expected 1", resp_hit_q.size()); end
    if (resp_hit_q.size() > 0) begin
      total++; if (resp_hit_q[0] !== 1'b0) begin bad++; $display("FAIL miss resp_hit: got %b expected 0", resp_hit_q[0]); end
      total++; if (resp_src_q[0] !== 5'd16) begin bad++; $display("FAIL miss resp_source: got %0d expected 16", resp_src_q[0]); end
    end
    total++; if (hit_way !== 5'd16) begin bad++; $display("FAIL miss hit_way: got %0d expected 16", hit_way); end
    check_counts("miss", 2, 1, 1);
  endtask

  task automatic test_back_pressure();
    l2_en = 1'b1; l2_echo = 1'b1; l2_lat = 20;
    for (int i = 0; i < 9; i++) begin
      miss_valid = 1'b1;
      miss_index = 10'h040 + 10'(i);
      miss_way   = 5'(i);
      total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL bp ready_before_push%0d: got %b expected 1", i, miss_ready); end
      step();
    end
    miss_valid = 1'b0;
    total++; if (miss_ready !== 1'b0) begin bad++; $display("FAIL bp full: got %b expected 0", miss_ready); end
    collect(400);
    total++; if (n_start !== 8) begin bad++; $display("FAIL bp strobes: got %0d expected 8", n_start); end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL bp hold: got %0d changes expected 0", hold_bad); end
    total++; if (resp_src_q.size() !== 9) begin bad++; $display("FAIL bp resp_pulses: got %0d expected 9", resp_src_q.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < resp_src_q.size()) begin
        logic [5:0] exp_v;
        exp_v = {1'(i & 1), 5'(i)};
        total++;
        if ({resp_hit_q[i], resp_src_q[i]} !== exp_v) begin
          bad++; $display("FAIL bp order%0d: got hit=%b src=%0d expected hit=%b src=%0d",
                          i, resp_hit_q[i], resp_src_q[i], exp_v[5], exp_v[4:0]);
        end
      end
    end
    total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL bp ready_after: got %b expected 1", miss_ready); end
    check_counts("bp", 11, 5, 6);
  endtask

  task automatic test_watchdog();
    l2_en = 1'b0;
    miss_valid = 1'b1; miss_index = 10'h1FF; miss_way = 5'd7;
    step();
    miss_valid = 1'b0;
    step();
    total++; if (find_start !== 1'b1) begin bad++; $display("FAIL wdog strobe: got %b expected 1", find_start); end
    repeat (63) step();
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL wdog early: got %b expected 0 at 63", err_timeout); end
    step();
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL wdog fire: got %b expected 1 at 64", err_timeout); end
    miss_valid = 1'b1; miss_index = 10'h011; miss_way = 5'd1;
    step();
    miss_valid = 1'b0;
    total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL wdog halt_accepts: got %b expected 1", miss_ready); end
    collect(30);
    total++; if (n_start !== 0) begin bad++; $display("FAIL wdog halt_strobes: got %0d expected 0", n_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wdog busy: got %b expected 1", busy); end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL wdog sticky: got %b expected 1", err_timeout); end
    check_counts("wdog", 11, 5, 6);
  endtask

  task automatic test_reset_mid_wait();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_wait err_cleared: got %b expected 0", err_timeout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_wait idle: got %b expected 0", busy); end
    l2_en = 1'b1; l2_echo = 1'b0; l2_lat = 10; l2_found = 1'b1; l2_src = 5'd3;
    miss_valid = 1'b1; miss_index = 10'h123; miss_way = 5'd4;
    step();
    miss_index = 10'h124; miss_way = 5'd5;
    step();
    miss_valid = 1'b0;
    total++; if (find_start !== 1'b1) begin bad++; $display("FAIL rst_wait strobe: got %b expected 1", find_start); end
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    collect(30);
    total++; if (n_start !== 0) begin bad++; $display("FAIL rst_wait strobes: got %0d expected 0", n_start); end
    total++; if (resp_src_q.size() !== 0) begin bad++; $display("FAIL rst_wait resp_pulses: got %0d expected 0", resp_src_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_wait busy: got %b expected 0", busy); end
    total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL rst_wait ready: got %b expected 1", miss_ready); end
    total++; if (msb_index !== 10'h000) begin bad++; $display("FAIL rst_wait msb_index: got %h expected 000", msb_index); end
    check_counts("rst_wait", 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_miss();
    test_back_pressure();
    test_watchdog();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
